// File: rtl/axis_complex_to_real_if.sv
// AXI-Stream bundle shared by the complex input and real output of the fs/4 mixer.
// WIDTH is the tdata width of this particular link (2*DATA_WIDTH in, DATA_WIDTH out).
interface axis_complex_to_real_if #(
  parameter int WIDTH = 16
) ();

  logic [WIDTH-1:0] tdata;
  logic             tvalid;
  logic             tready;
  logic             tlast;

  modport master (
    output tdata,
    output tvalid,
    output tlast,
    input  tready
  );

  modport slave (
    input  tdata,
    input  tvalid,
    input  tlast,
    output tready
  );

endinterface

// File: rtl/axis_complex_to_real.sv
// fs/4 upconverter: y[n] = Re{(I + jQ) * j^p}, with saturating negation and an optional
// registered output stage backed by a two-entry skid buffer.
module axis_complex_to_real #(
  parameter int DATA_WIDTH     = 16,
  parameter int OPT_REGISTER   = 1,
  parameter int OPT_LAST_RESET = 1
) (
  input  logic                   aclk,
  input  logic                   areset,
  axis_complex_to_real_if.slave  s_axis,
  axis_complex_to_real_if.master m_axis
);

  localparam logic [DATA_WIDTH-1:0] MOST_NEG = {1'b1, {(DATA_WIDTH-1){1'b0}}};
  localparam logic [DATA_WIDTH-1:0] MOST_POS = {1'b0, {(DATA_WIDTH-1){1'b1}}};

  // Occupancy of the output register plus skid register.
  typedef enum logic [1:0] {
    ST_EMPTY,
    ST_BUSY,
    ST_FULL
  } buf_state_e;

  logic [DATA_WIDTH-1:0] w_i;
  logic [DATA_WIDTH-1:0] w_q;
  logic [DATA_WIDTH-1:0] w_mixed;
  logic                  w_s_ready;
  logic                  w_accept;
  logic [1:0]            r_phase;

  function automatic logic [DATA_WIDTH-1:0] neg_sat(input logic [DATA_WIDTH-1:0] x);
    if (x == MOST_NEG) return MOST_POS;
    return -x;
  endfunction

  assign w_i           = s_axis.tdata[DATA_WIDTH-1:0];
  assign w_q           = s_axis.tdata[2*DATA_WIDTH-1:DATA_WIDTH];
  assign w_accept      = s_axis.tvalid && w_s_ready && !areset;
  assign s_axis.tready = w_s_ready;

  // The mixed value is formed here, at acceptance, so later stalls cannot alter it.
  always_comb begin
    case (r_phase)
      2'd0:    w_mixed = w_i;
      2'd1:    w_mixed = neg_sat(w_q);
      2'd2:    w_mixed = neg_sat(w_i);
      default: w_mixed = w_q;
    endcase
  end

  // NOTE: clocked state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge aclk) begin
    if (areset) begin
      r_phase <= 2'd0;
    end else if (w_accept) begin
      if ((OPT_LAST_RESET != 0) && s_axis.tlast) r_phase <= 2'd0;
      else                                       r_phase <= r_phase + 2'd1;
    end
  end

  generate
    if (OPT_REGISTER != 0) begin : g_registered
      buf_state_e            r_state;
      buf_state_e            w_state_nxt;
      logic                  w_load_out;
      logic                  w_load_skid;
      logic                  w_skid_to_out;
      logic [DATA_WIDTH-1:0] r_out_data;
      logic [DATA_WIDTH-1:0] r_skid_data;
      logic                  r_out_last;
      logic                  r_skid_last;

      always_ff @(posedge aclk) begin
        if (areset) r_state <= ST_EMPTY;
        else        r_state <= w_state_nxt;
      end

      // NOTE: every output of this block is defaulted first, so no path can infer a latch.
      always_comb begin
        w_state_nxt   = r_state;
        w_load_out    = 1'b0;
        w_load_skid   = 1'b0;
        w_skid_to_out = 1'b0;
        case (r_state)
          ST_EMPTY: begin
            if (w_accept) begin
              w_load_out  = 1'b1;
              w_state_nxt = ST_BUSY;
            end
          end
          ST_BUSY: begin
            if (w_accept && m_axis.tready) begin
              w_load_out = 1'b1;
            end else if (w_accept) begin
              w_load_skid = 1'b1;
              w_state_nxt = ST_FULL;
            end else if (m_axis.tready) begin
              w_state_nxt = ST_EMPTY;
            end
          end
          ST_FULL: begin
            // Input is blocked while full, so only the drain transition exists.
            if (m_axis.tready) begin
              w_skid_to_out = 1'b1;
              w_state_nxt   = ST_BUSY;
            end
          end
          default: w_state_nxt = ST_EMPTY;
        endcase
      end

      // NOTE: payload registers carry no reset; validity lives entirely in r_state.
      always_ff @(posedge aclk) begin
        if (w_load_out) begin
          r_out_data <= w_mixed;
          r_out_last <= s_axis.tlast;
        end else if (w_skid_to_out) begin
          r_out_data <= r_skid_data;
          r_out_last <= r_skid_last;
        end
        if (w_load_skid) begin
          r_skid_data <= w_mixed;
          r_skid_last <= s_axis.tlast;
        end
      end

      // Ready comes from registered occupancy only; m_axis.tready never reaches it.
      assign w_s_ready     = (r_state != ST_FULL) && !areset;
      assign m_axis.tvalid = (r_state != ST_EMPTY);
      assign m_axis.tdata  = r_out_data;
      assign m_axis.tlast  = r_out_last;
    end else begin : g_combinational
      assign w_s_ready     = m_axis.tready;
      assign m_axis.tvalid = s_axis.tvalid;
      assign m_axis.tdata  = w_mixed;
      assign m_axis.tlast  = s_axis.tlast;
    end
  endgenerate

endmodule

// File: tb/tb_axis_complex_to_real.sv
// Directed bench for the fs/4 upconverter: registered/last-reset instance plus a
// combinational/free-running-phase instance sharing clock and reset.
module tb_axis_complex_to_real;

  localparam int DW = 16;

  logic aclk   = 1'b0;
  logic areset = 1'b1;
  always #5 aclk = ~aclk;

  axis_complex_to_real_if #(.WIDTH(2*DW)) s0 ();
  axis_complex_to_real_if #(.WIDTH(DW))   m0 ();
  axis_complex_to_real_if #(.WIDTH(2*DW)) s1 ();
  axis_complex_to_real_if #(.WIDTH(DW))   m1 ();

  axis_complex_to_real #(.DATA_WIDTH(DW), .OPT_REGISTER(1), .OPT_LAST_RESET(1)) dut0 (
    .aclk(aclk), .areset(areset), .s_axis(s0), .m_axis(m0));
  axis_complex_to_real #(.DATA_WIDTH(DW), .OPT_REGISTER(0), .OPT_LAST_RESET(0)) dut1 (
    .aclk(aclk), .areset(areset), .s_axis(s1), .m_axis(m1));

  int n_tests = 0;
  int n_fail  = 0;

  int          q_i[$];
  int          q_q[$];
  bit          q_last[$];
  logic [15:0] o_d[$];
  logic        o_l[$];
  int          cycles;
  int          stall_viol;
  bit          timed_out;

  function automatic int sat_neg(int x);
    return (x == -32768) ? 32767 : -x;
  endfunction

  function automatic logic [15:0] ref_mix(int i, int q, int p);
    case (p)
      0:       return 16'(i);
      1:       return 16'(sat_neg(q));
      2:       return 16'(sat_neg(i));
      default: return 16'(q);
    endcase
  endfunction

  function automatic logic [15:0] out_at(int k);
    if (k < o_d.size()) return o_d[k];
    return 16'bx;
  endfunction

  function automatic logic last_at(int k);
    if (k < o_l.size()) return o_l[k];
    return 1'bx;
  endfunction

  task automatic clear_stim();
    q_i.delete();
    q_q.delete();
    q_last.delete();
  endtask

  task automatic add_beat(int i, int q, bit last);
    q_i.push_back(i);
    q_q.push_back(q);
    q_last.push_back(last);
  endtask

  task automatic do_reset();
    @(posedge aclk); #1;
    areset    = 1'b1;
    s0.tvalid = 1'b0;
    s1.tvalid = 1'b0;
    @(posedge aclk); #1;
    areset = 1'b0;
  endtask

  // Streams the queued beats into one instance (sel) and collects its output beats.
  task automatic run_stream(bit sel, int ready_pct, int valid_pct, int budget);
    int          idx = 0;
    bit          vld = 1'b0;
    bit          rdy;
    bit          prev_stall = 1'b0;
    logic [15:0] pd = '0;
    logic        pl = 1'b0;
    o_d.delete();
    o_l.delete();
    cycles     = 0;
    stall_viol = 0;
    timed_out  = 1'b0;
    while (o_d.size() < q_i.size()) begin
      if (cycles >= budget) begin
        timed_out = 1'b1;
        break;
      end
      @(posedge aclk); #1;
      cycles++;
      if (!vld && idx < q_i.size() && $urandom_range(99) < valid_pct) vld = 1'b1;
      rdy = ($urandom_range(99) < ready_pct);
      if (sel) begin
        s1.tvalid = vld;
        if (vld) begin
          s1.tdata = {16'(q_q[idx]), 16'(q_i[idx])};
          s1.tlast = q_last[idx];
        end
        m1.tready = rdy;
      end else begin
        s0.tvalid = vld;
        if (vld) begin
          s0.tdata = {16'(q_q[idx]), 16'(q_i[idx])};
          s0.tlast = q_last[idx];
        end
        m0.tready = rdy;
      end
      @(negedge aclk);
      if (sel) begin
        if (s1.tvalid && s1.tready) begin
          idx++;
          vld = 1'b0;
        end
        if (m1.tvalid && m1.tready) begin
          o_d.push_back(m1.tdata);
          o_l.push_back(m1.tlast);
        end
      end else begin
        if (s0.tvalid && s0.tready) begin
          idx++;
          vld = 1'b0;
        end
        if (prev_stall && (m0.tvalid !== 1'b1 || m0.tdata !== pd || m0.tlast !== pl))
          stall_viol++;
        prev_stall = m0.tvalid && !m0.tready;
        pd = m0.tdata;
        pl = m0.tlast;
        if (m0.tvalid && m0.tready) begin
          o_d.push_back(m0.tdata);
          o_l.push_back(m0.tlast);
        end
      end
    end
    @(posedge aclk); #1;
    s0.tvalid = 1'b0;
    s1.tvalid = 1'b0;
    m0.tready = 1'b1;
    m1.tready = 1'b1;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge aclk);
    @(negedge aclk);
    n_tests++;
    if (m0.tvalid !== 1'b0) begin n_fail++; $display("FAIL reset_m0_tvalid: got %b want 0", m0.tvalid); end
    n_tests++;
    if (s0.tready !== 1'b0) begin n_fail++; $display("FAIL reset_s0_tready: got %b want 0", s0.tready); end
    n_tests++;
    if (m1.tvalid !== 1'b0) begin n_fail++; $display("FAIL reset_m1_tvalid: got %b want 0", m1.tvalid); end
    @(posedge aclk); #1;
    areset = 1'b0;
    @(negedge aclk);
    n_tests++;
    if (s0.tready !== 1'b1) begin n_fail++; $display("FAIL post_reset_s0_tready: got %b want 1", s0.tready); end
    n_tests++;
    if (m0.tvalid !== 1'b0) begin n_fail++; $display("FAIL post_reset_m0_tvalid: got %b want 0", m0.tvalid); end
  endtask

  task automatic test_free_run();
    int exp[5] = '{100, -200, -100, 200, 100};
    do_reset();
    clear_stim();
    repeat (5) add_beat(100, 200, 1'b0);
    run_stream(1'b0, 100, 100, 50);
    n_tests++;
    if (timed_out) begin n_fail++; $display("FAIL free_run_timeout: got %0d outputs want 5", o_d.size()); end
    for (int k = 0; k < 5; k++) begin
      n_tests++;
      if (out_at(k) !== 16'(exp[k])) begin
        n_fail++;
        $display("FAIL free_run[%0d]: got %0d want %0d", k, $signed(out_at(k)), exp[k]);
      end
    end
  endtask

  task automatic test_saturation();
    int exp[5] = '{-32768, 32767, 32767, -32768, -32768};
    do_reset();
    clear_stim();
    repeat (5) add_beat(-32768, -32768, 1'b0);
    run_stream(1'b0, 100, 100, 50);
    for (int k = 0; k < 5; k++) begin
      n_tests++;
      if (out_at(k) !== 16'(exp[k])) begin
        n_fail++;
        $display("FAIL saturation[%0d]: got %0d want %0d", k, $signed(out_at(k)), exp[k]);
      end
    end
  endtask

  // Same three beats into both instances: last-reset phase vs free-running phase.
  task automatic test_tlast();
    int exp_reg[3]  = '{10, -20, 10};
    int exp_free[3] = '{10, -20, -10};
    bit exp_last[3] = '{1'b0, 1'b1, 1'b0};
    do_reset();
    clear_stim();
    add_beat(10, 20, 1'b0);
    add_beat(10, 20, 1'b1);
    add_beat(10, 20, 1'b0);
    run_stream(1'b0, 100, 100, 50);
    for (int k = 0; k < 3; k++) begin
      n_tests++;
      if (out_at(k) !== 16'(exp_reg[k])) begin
        n_fail++;
        $display("FAIL tlast_reset_data[%0d]: got %0d want %0d", k, $signed(out_at(k)), exp_reg[k]);
      end
      n_tests++;
      if (last_at(k) !== exp_last[k]) begin
        n_fail++;
        $display("FAIL tlast_reset_last[%0d]: got %b want %b", k, last_at(k), exp_last[k]);
      end
    end
    run_stream(1'b1, 100, 100, 50);
    for (int k = 0; k < 3; k++) begin
      n_tests++;
      if (out_at(k) !== 16'(exp_free[k])) begin
        n_fail++;
        $display("FAIL tlast_free_data[%0d]: got %0d want %0d", k, $signed(out_at(k)), exp_free[k]);
      end
      n_tests++;
      if (last_at(k) !== exp_last[k]) begin
        n_fail++;
        $display("FAIL tlast_free_last[%0d]: got %b want %b", k, last_at(k), exp_last[k]);
      end
    end
  endtask

  task automatic test_throughput();
    do_reset();
    clear_stim();
    for (int k = 0; k < 64; k++) add_beat(3 * k, 1000 - k, k == 63);
    run_stream(1'b0, 100, 100, 200);
    n_tests++;
    if (cycles != 65) begin n_fail++; $display("FAIL throughput_cycles: got %0d want 65", cycles); end
    for (int k = 0; k < 64; k++) begin
      n_tests++;
      if (out_at(k) !== ref_mix(3 * k, 1000 - k, k % 4)) begin
        n_fail++;
        $display("FAIL throughput_data[%0d]: got %0d want %0d", k, $signed(out_at(k)),
                 $signed(ref_mix(3 * k, 1000 - k, k % 4)));
      end
      n_tests++;
      if (last_at(k) !== (k == 63)) begin
        n_fail++;
        $display("FAIL throughput_last[%0d]: got %b want %b", k, last_at(k), k == 63);
      end
    end
  endtask

  task automatic test_skid_and_reset();
    int leaked = 0;
    do_reset();
    m0.tready = 1'b0;
    s0.tvalid = 1'b1;
    s0.tdata  = {16'd2, 16'd1};
    s0.tlast  = 1'b0;
    @(negedge aclk);
    n_tests++;
    if (s0.tready !== 1'b1) begin n_fail++; $display("FAIL skid_ready_a: got %b want 1", s0.tready); end
    @(posedge aclk); #1;
    s0.tdata = {16'd4, 16'd3};
    @(negedge aclk);
    n_tests++;
    if (m0.tvalid !== 1'b1 || m0.tdata !== 16'd1) begin
      n_fail++;
      $display("FAIL skid_first_out: got valid=%b data=%0d want valid=1 data=1", m0.tvalid, m0.tdata);
    end
    n_tests++;
    if (s0.tready !== 1'b1) begin n_fail++; $display("FAIL skid_ready_b: got %b want 1", s0.tready); end
    @(posedge aclk); #1;
    s0.tdata = {16'd6, 16'd5};
    @(negedge aclk);
    n_tests++;
    if (s0.tready !== 1'b0) begin n_fail++; $display("FAIL skid_full_ready: got %b want 0", s0.tready); end
    n_tests++;
    if (m0.tdata !== 16'd1) begin n_fail++; $display("FAIL skid_stall_hold: got %0d want 1", m0.tdata); end
    #1 m0.tready = 1'b1;
    #1;
    n_tests++;
    if (s0.tready !== 1'b0) begin n_fail++; $display("FAIL skid_ready_comb_path: got %b want 0", s0.tready); end
    m0.tready = 1'b0;
    // Two beats held (A in output, B in skid); reset must discard both.
    @(posedge aclk); #1;
    areset = 1'b1;
    @(posedge aclk); #1;
    areset    = 1'b0;
    s0.tvalid = 1'b0;
    m0.tready = 1'b1;
    @(negedge aclk);
    n_tests++;
    if (m0.tvalid !== 1'b0) begin n_fail++; $display("FAIL midreset_tvalid: got %b want 0", m0.tvalid); end
    repeat (3) begin
      @(negedge aclk);
      if (m0.tvalid !== 1'b0) leaked++;
    end
    n_tests++;
    if (leaked != 0) begin n_fail++; $display("FAIL midreset_leak: got %0d valid cycles want 0", leaked); end
    clear_stim();
    add_beat(7, 9, 1'b0);
    run_stream(1'b0, 100, 100, 20);
    n_tests++;
    if (out_at(0) !== 16'd7) begin n_fail++; $display("FAIL midreset_phase: got %0d want 7", $signed(out_at(0))); end
  endtask

  task automatic test_backpressure();
    logic [15:0] exp[$];
    bit          exp_l[$];
    int          p = 0;
    int          i_v;
    int          q_v;
    bit          l_v;
    do_reset();
    clear_stim();
    for (int k = 0; k < 1000; k++) begin
      i_v = (k % 17 == 0) ? -32768 : int'($urandom_range(65535)) - 32768;
      q_v = (k % 13 == 0) ? -32768 : int'($urandom_range(65535)) - 32768;
      l_v = ($urandom_range(7) == 0);
      add_beat(i_v, q_v, l_v);
      exp.push_back(ref_mix(i_v, q_v, p));
      exp_l.push_back(l_v);
      p = l_v ? 0 : (p + 1) % 4;
    end
    run_stream(1'b0, 50, 80, 20000);
    n_tests++;
    if (timed_out) begin n_fail++; $display("FAIL backpressure_timeout: got %0d outputs want 1000", o_d.size()); end
    n_tests++;
    if (stall_viol != 0) begin n_fail++; $display("FAIL backpressure_stall_hold: got %0d violations want 0", stall_viol); end
    for (int k = 0; k < 1000; k++) begin
      n_tests++;
      if (out_at(k) !== exp[k] || last_at(k) !== exp_l[k]) begin
        n_fail++;
        $display("FAIL backpressure[%0d]: got %0d/%b want %0d/%b", k, $signed(out_at(k)), last_at(k),
                 $signed(exp[k]), exp_l[k]);
      end
    end
  endtask

  initial begin
    s0.tvalid = 1'b0; s0.tdata = '0; s0.tlast = 1'b0;
    s1.tvalid = 1'b0; s1.tdata = '0; s1.tlast = 1'b0;
    m0.tready = 1'b1;
    m1.tready = 1'b1;
    test_reset();
    test_free_run();
    test_saturation();
    test_tlast();
    test_throughput();
    test_skid_and_reset();
    test_backpressure();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/axis_complex_to_real.md
AXIS_COMPLEX_TO_REAL -- requirements
Module: axis_complex_to_real

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16, bit width of each real component (I or Q) and of the output sample.
REQ-002 SHALL have parameter OPT_REGISTER, default 1: 0 = combinational datapath; 1 = registered output with skid buffer on input.
REQ-003 SHALL have parameter OPT_LAST_RESET, default 1: 1 = mixer phase returns to 0 after each accepted tlast beat; 0 = phase runs free.
REQ-004 SHALL have port aclk, input, 1, the single clock; all logic on its rising edge.
REQ-005 SHALL have port areset, input, 1, reset; synchronous and active-high.
REQ-006 SHALL have port s_axis_tdata, input, 2*DATA_WIDTH, complex sample: [DATA_WIDTH-1:0] = I (real), [2*DATA_WIDTH-1:DATA_WIDTH] = Q (imag), both two's complement.
REQ-007 SHALL have ports s_axis_tvalid (input, 1), s_axis_tlast (input, 1) and s_axis_tready (output, 1), the AXI-Stream slave handshake.
REQ-008 SHALL have port m_axis_tdata, output, DATA_WIDTH, real two's-complement output sample.
REQ-009 SHALL have ports m_axis_tvalid (output, 1), m_axis_tlast (output, 1) and m_axis_tready (input, 1), the AXI-Stream master handshake.

Function
REQ-010 SHALL output y[n] = Re{(I[n] + jQ[n]) * j^p}, i.e. an fs/4 upconversion, where p is a 2-bit phase counter.
REQ-011 SHALL map phase to output: p=0 -> I; p=1 -> -Q; p=2 -> -I; p=3 -> Q.
REQ-012 SHALL saturate negation: negating -2^(DATA_WIDTH-1) yields 2^(DATA_WIDTH-1)-1; no other rounding and no width growth.
REQ-013 SHALL advance p by 1 (mod 4, 3 wraps to 0) only on an accepted input beat (s_axis_tvalid && s_axis_tready); p holds otherwise.
REQ-014 SHALL, when OPT_LAST_RESET=1, set p to 0 after an accepted beat with s_axis_tlast=1, overriding the increment; the tlast beat itself uses its current p.
REQ-015 SHALL pass tlast through with the sample it belongs to, with no reordering, insertion or dropping of beats.
REQ-016 SHALL, with OPT_REGISTER=0: m_axis_tvalid = s_axis_tvalid, s_axis_tready = m_axis_tready, m_axis_tlast = s_axis_tlast, m_axis_tdata combinational from inputs and p; latency 0.
REQ-017 SHALL, with OPT_REGISTER=1, have latency 1 cycle from input acceptance to m_axis_tvalid, and sustain one beat per cycle while m_axis_tready=1.
REQ-018 SHALL, with OPT_REGISTER=1, hold m_axis_tdata/m_axis_tlast stable and m_axis_tvalid high while m_axis_tvalid && !m_axis_tready (stall).
REQ-019 SHALL, with OPT_REGISTER=1, derive s_axis_tready from a registered signal (2-entry skid buffer); no combinational path from m_axis_tready to s_axis_tready.
REQ-020 SHALL, with OPT_REGISTER=1, accept at most one beat into the skid buffer during a stall, then deassert s_axis_tready until the stall clears; no beat lost or duplicated.
REQ-021 SHALL compute the phase-dependent value at input acceptance, so that a stall never changes the sample already presented.

Reset
REQ-022 SHALL, on areset=1 at a clock edge: p=0, m_axis_tvalid=0, skid buffer empty, s_axis_tready=0 during reset and =1 on the first cycle after reset deasserts (OPT_REGISTER=1).
REQ-023 SHALL discard any buffered or in-flight beat when reset asserts mid-stream; m_axis_tdata/m_axis_tlast reset values are don't-care, m_axis_tvalid is not.
REQ-024 SHALL ignore input handshakes in any cycle in which areset=1.

Verification
REQ-025 Free-run: DATA_WIDTH=16, m_axis_tready=1, feed (I,Q) = (100,200) x4 -> outputs 100, -200, -100, 200; 5th beat -> 100.
REQ-026 Saturation: input (I,Q) = (-32768, -32768) at p=1 and p=2 -> output 32767 both; at p=0 -> -32768.
REQ-027 tlast phase reset: OPT_LAST_RESET=1, beats (10,20),(10,20,last),(10,20) -> 10, -20, 10; same with OPT_LAST_RESET=0 -> 10, -20, -10.
REQ-028 Backpressure: OPT_REGISTER=1, random m_axis_tready at 50%, 1000 random beats -> output sequence equals the reference model, tdata/tlast stable during every stall, s_axis_tready never combinationally dependent on m_axis_tready.
REQ-029 Reset mid-stream: stall with 2 beats held, pulse areset 1 cycle -> m_axis_tvalid=0 next cycle, no held beat emerges, first post-reset beat uses p=0.
REQ-030 Throughput: OPT_REGISTER=1, continuous valid/ready for 64 beats -> 64 outputs in 65 cycles, tlast on output 64 when set on input 64.
